// File: rtl/marquee_scan.sv
// marquee_scan: row-scanned RGB LED-matrix marquee driven by debounced colour and mode buttons.
// Build option MARQUEE_PAUSE_EN adds btn_pause, which freezes pattern stepping while scanning continues.
module marquee_scan #(
    parameter int unsigned ROWS        = 8,
    parameter int unsigned COLS        = 8,
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned STEP_HZ     = 2,
    parameter int unsigned SCAN_HZ     = 8_000,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_color,
    input  logic            btn_mode,
`ifdef MARQUEE_PAUSE_EN
    input  logic            btn_pause,
`endif
    output logic [ROWS-1:0] led_row,
    output logic [COLS-1:0] led_col_r,
    output logic [COLS-1:0] led_col_g,
    output logic [COLS-1:0] led_col_b,
    output logic            led_hb
);

    localparam int unsigned DBC_RAW = DEBOUNCE_MS * CLK_FREQ / 1000;
    localparam int unsigned DBC     = (DBC_RAW == 0) ? 1 : DBC_RAW;
    localparam int unsigned DBC_W   = $clog2(DBC + 1);
    localparam int unsigned STEP_RAW = CLK_FREQ / STEP_HZ;
    localparam int unsigned STEP_N  = (STEP_RAW == 0) ? 1 : STEP_RAW;
    localparam int unsigned STEP_W  = $clog2(STEP_N + 1);
    localparam int unsigned SCAN_RAW = CLK_FREQ / SCAN_HZ;
    localparam int unsigned SCAN_N  = (SCAN_RAW == 0) ? 1 : SCAN_RAW;
    localparam int unsigned SCAN_W  = $clog2(SCAN_N + 1);
    localparam int unsigned POS_W   = $clog2(COLS);
    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned BTN_COLOR = 0;
    localparam int unsigned BTN_MODE  = 1;
`ifdef MARQUEE_PAUSE_EN
    localparam int unsigned BTN_PAUSE = 2;
    localparam int unsigned NBTN      = 3;
`else
    localparam int unsigned NBTN      = 2;
`endif

    localparam logic [1:0] MODE_LEFT   = 2'd0;
    localparam logic [1:0] MODE_RIGHT  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    logic [NBTN-1:0]  btn_raw_c;
    logic [NBTN-1:0]  sync1, sync2, db, armed, press;
    logic [DBC_W-1:0] dbc_cnt [NBTN];
    logic [1:0]       settle;

`ifdef MARQUEE_PAUSE_EN
    assign btn_raw_c = {btn_pause, btn_mode, btn_color};
`else
    assign btn_raw_c = {btn_mode, btn_color};
`endif

    // Synchronise, debounce and edge-detect every button. A button only becomes
    // armed once it has been seen released after reset, so a button held through
    // reset cannot produce a press until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            db     <= '1;
            armed  <= '0;
            press  <= '0;
            settle <= '0;
            for (int i = 0; i < int'(NBTN); i++) dbc_cnt[i] <= '0;
        end else begin
            sync1  <= btn_raw_c;
            sync2  <= sync1;
            settle <= {settle[0], 1'b1};
            for (int i = 0; i < int'(NBTN); i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != db[i]) begin
                    if (dbc_cnt[i] == DBC_W'(DBC - 1)) begin
                        db[i]      <= sync2[i];
                        dbc_cnt[i] <= '0;
                        press[i]   <= armed[i] & ~sync2[i];
                    end else begin
                        dbc_cnt[i] <= dbc_cnt[i] + DBC_W'(1);
                    end
                end else begin
                    dbc_cnt[i] <= '0;
                    if (settle[1] && db[i] && (dbc_cnt[i] == '0)) armed[i] <= 1'b1;
                end
            end
        end
    end

    logic step_run_c;
`ifdef MARQUEE_PAUSE_EN
    logic paused;

    always_ff @(posedge clk) begin
        if (rst) paused <= 1'b0;
        else     paused <= paused ^ press[BTN_PAUSE];
    end

    assign step_run_c = ~paused;
`else
    assign step_run_c = 1'b1;
`endif

    // Pattern engine state
    logic [2:0]        col, col_n;
    logic [1:0]        mode, mode_n;
    logic [POS_W-1:0]  pos, pos_n;
    logic              dir_down, dir_n;
    logic [STEP_W-1:0] step_cnt, step_cnt_n;
    logic              hb, hb_n;
    logic              step_tick_c, any_press_c;

    assign step_tick_c = step_run_c && (step_cnt == STEP_W'(STEP_N - 1));
    assign any_press_c = press[BTN_COLOR] | press[BTN_MODE];

    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= 3'd1;
            mode     <= MODE_LEFT;
            pos      <= '0;
            dir_down <= 1'b0;
            step_cnt <= '0;
            hb       <= 1'b0;
        end else begin
            col      <= col_n;
            mode     <= mode_n;
            pos      <= pos_n;
            dir_down <= dir_n;
            step_cnt <= step_cnt_n;
            hb       <= hb_n;
        end
    end

    // A press restarts the pattern and swallows any coincident step.
    always_comb begin
        col_n      = col;
        mode_n     = mode;
        pos_n      = pos;
        dir_n      = dir_down;
        step_cnt_n = step_cnt;
        hb_n       = hb;
        if (step_run_c) step_cnt_n = step_tick_c ? '0 : step_cnt + STEP_W'(1);
        if (any_press_c) begin
            if (press[BTN_COLOR]) col_n  = col + 3'd1;
            if (press[BTN_MODE])  mode_n = mode + 2'd1;
            pos_n      = '0;
            dir_n      = 1'b0;
            step_cnt_n = '0;
        end else if (step_tick_c) begin
            hb_n = ~hb;
            case (mode)
                MODE_RIGHT: pos_n = (pos == '0) ? POS_W'(COLS - 1) : pos - POS_W'(1);
                MODE_BOUNCE: begin
                    if (!dir_down) begin
                        if (pos == POS_W'(COLS - 1)) begin
                            pos_n = POS_W'(COLS - 2);
                            dir_n = 1'b1;
                        end else begin
                            pos_n = pos + POS_W'(1);
                        end
                    end else if (pos == '0) begin
                        pos_n = POS_W'(1);
                        dir_n = 1'b0;
                    end else begin
                        pos_n = pos - POS_W'(1);
                    end
                end
                default: pos_n = (pos == POS_W'(COLS - 1)) ? '0 : pos + POS_W'(1);
            endcase
        end
    end

    // Row scanning runs independently of stepping and pause.
    logic [SCAN_W-1:0] scan_cnt;
    logic [ROW_W-1:0]  row_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            row_idx  <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_N - 1)) begin
            scan_cnt <= '0;
            row_idx  <= (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + ROW_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    logic [COLS-1:0] pat_c;

    always_comb begin
        pat_c = '0;
        for (int unsigned c = 0; c < COLS; c++)
            pat_c[c] = (mode == MODE_FILL) ? (c <= 32'(pos)) : (c == 32'(pos));
    end

    // Pins stay dark for the reset cycle and the one after it.
    logic rst_d;

    always_ff @(posedge clk) begin
        rst_d <= rst;
        if (rst || rst_d) begin
            led_row   <= '0;
            led_col_r <= '1;
            led_col_g <= '1;
            led_col_b <= '1;
            led_hb    <= 1'b0;
        end else begin
            led_row   <= ROWS'(1) << row_idx;
            led_col_r <= ~(pat_c & {COLS{col[0]}});
            led_col_g <= ~(pat_c & {COLS{col[1]}});
            led_col_b <= ~(pat_c & {COLS{col[2]}});
            led_hb    <= hb;
        end
    end

endmodule

// File: tb/tb_marquee_scan.sv
// tb_marquee_scan: directed, table-driven bench for marquee_scan with short step/scan/debounce periods.
module tb_marquee_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_color = 1'b1;
    logic       btn_mode = 1'b1;
`ifdef MARQUEE_PAUSE_EN
    logic       btn_pause = 1'b1;
`endif
    logic [7:0] led_row, led_col_r, led_col_g, led_col_b;
    logic       led_hb;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    marquee_scan #(
        .ROWS(8), .COLS(8), .CLK_FREQ(1000), .STEP_HZ(100), .SCAN_HZ(500), .DEBOUNCE_MS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_color(btn_color),
        .btn_mode(btn_mode),
`ifdef MARQUEE_PAUSE_EN
        .btn_pause(btn_pause),
`endif
        .led_row(led_row),
        .led_col_r(led_col_r),
        .led_col_g(led_col_g),
        .led_col_b(led_col_b),
        .led_hb(led_hb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       btn_c;
        logic       btn_m;
        logic [7:0] row;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hb;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %02h expected %02h", name, cyc, act, exp);
        end
    endtask

    task automatic check_rgb(input string name, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b);
        check8({name, ".r"}, led_col_r, r);
        check8({name, ".g"}, led_col_g, g);
        check8({name, ".b"}, led_col_b, b);
    endtask

    // Hold the selected buttons low for 5 cycles, then release for 6.
    // The press takes effect 5 edges after the drive, so this returns 6 cycles after it.
    task automatic press(input logic c, input logic m);
        btn_color = ~c;
        btn_mode  = ~m;
        repeat (5) tick();
        btn_color = 1'b1;
        btn_mode  = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bseq[16];
        logic [7:0] fseq[9];
        logic [7:0] one;

        bseq = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        fseq = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'hFE};
        one  = 8'h01;

        vecs[0] = '{1,  1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        vecs[1] = '{2,  1'b1, 1'b1, 8'h01, 8'hFE, 8'hFF, 8'hFF, 1'b0};
        vecs[2] = '{3,  1'b1, 1'b1, 8'h02, 8'hFE, 8'hFF, 8'hFF, 1'b0};
        vecs[3] = '{5,  1'b1, 1'b1, 8'h04, 8'hFE, 8'hFF, 8'hFF, 1'b0};
        vecs[4] = '{10, 1'b1, 1'b1, 8'h10, 8'hFE, 8'hFF, 8'hFF, 1'b0};
        vecs[5] = '{11, 1'b1, 1'b1, 8'h20, 8'hFD, 8'hFF, 8'hFF, 1'b1};
        vecs[6] = '{17, 1'b1, 1'b1, 8'h01, 8'hFD, 8'hFF, 8'hFF, 1'b1};
        vecs[7] = '{21, 1'b1, 1'b1, 8'h04, 8'hFB, 8'hFF, 8'hFF, 1'b0};
        vecs[8] = '{31, 1'b1, 1'b1, 8'h80, 8'hF7, 8'hFF, 8'hFF, 1'b1};
        vecs[9] = '{41, 1'b1, 1'b1, 8'h10, 8'hEF, 8'hFF, 8'hFF, 1'b0};

        // Reset: the third edge is cycle 0
        rst = 1'b1;
        repeat (3) tick();
        cyc = 0;
        check8("rst.row", led_row, 8'h00);
        check_rgb("rst", 8'hFF, 8'hFF, 8'hFF);
        check8("rst.hb", {7'd0, led_hb}, 8'h00);
        rst = 1'b0;

        // Idle run
        for (int i = 0; i < 10; i++) begin
            while (cyc < vecs[i].cyc) begin
                btn_color = vecs[i].btn_c;
                btn_mode  = vecs[i].btn_m;
                tick();
            end
            check8($sformatf("idle%0d.row", vecs[i].cyc), led_row, vecs[i].row);
            check_rgb($sformatf("idle%0d", vecs[i].cyc), vecs[i].r, vecs[i].g, vecs[i].b);
            check8($sformatf("idle%0d.hb", vecs[i].cyc), {7'd0, led_hb}, {7'd0, vecs[i].hb});
        end

        // One-cycle glitch on btn_color is ignored; pos keeps stepping (pos 4 by now)
        btn_color = 1'b0;
        tick();
        btn_color = 1'b1;
        repeat (6) tick();
        check_rgb("glitch", 8'hEF, 8'hFF, 8'hFF);

        // Real colour press: red -> green, pattern restarts at column 0
        press(1'b1, 1'b0);
        check_rgb("color1", 8'hFF, 8'hFE, 8'hFF);
        repeat (4) tick();
        check8("color1.hold.g", led_col_g, 8'hFE);
        tick();
        check8("color1.step.g", led_col_g, 8'hFD);
        repeat (20) tick();
        check_rgb("color1.once", 8'hFF, 8'hF7, 8'hFF);

        // LEFT -> RIGHT -> BOUNCE, then follow the bounce
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k != 0) repeat (10) tick();
            check8($sformatf("bounce%0d.g", k), led_col_g, ~(one << bseq[k]));
        end

        // BOUNCE -> FILL, colour 2 -> 7 (white)
        press(1'b0, 1'b1);
        repeat (5) press(1'b1, 1'b0);
        for (int k = 0; k < 9; k++) begin
            if (k != 0) repeat (10) tick();
            check_rgb($sformatf("fill%0d", k), fseq[k], fseq[k], fseq[k]);
        end

        // Colour 7 wraps to 0: everything dark
        press(1'b1, 1'b0);
        check_rgb("colwrap", 8'hFF, 8'hFF, 8'hFF);

        // Both presses land on a step tick: col 0->1, FILL->LEFT, step dropped
        repeat (9) tick();
        press(1'b1, 1'b1);
        check_rgb("both", 8'hFE, 8'hFF, 8'hFF);
        repeat (4) tick();
        check8("both.hold.r", led_col_r, 8'hFE);
        tick();
        check8("both.step.r", led_col_r, 8'hFD);

        // Reset in the middle of a btn_mode debounce, button kept held through reset
        btn_mode = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check8("rst2.row", led_row, 8'h00);
        check_rgb("rst2", 8'hFF, 8'hFF, 8'hFF);
        check8("rst2.hb", {7'd0, led_hb}, 8'h00);
        rst = 1'b0;
        tick();
        check8("rst2p1.row", led_row, 8'h00);
        check_rgb("rst2p1", 8'hFF, 8'hFF, 8'hFF);
        tick();
        check8("rst2p2.row", led_row, 8'h01);
        check_rgb("rst2p2", 8'hFE, 8'hFF, 8'hFF);
        repeat (14) tick();
        check_rgb("rst2p16", 8'hFD, 8'hFF, 8'hFF);
        check8("rst2p16.hb", {7'd0, led_hb}, 8'h01);
        repeat (5) tick();
        check8("rst2p21.r", led_col_r, 8'hFB);
        repeat (9) tick();
        btn_mode = 1'b1;
        repeat (11) tick();
        check8("rst2p41.row", led_row, 8'h10);
        check_rgb("rst2p41", 8'hEF, 8'hFF, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/marquee_scan.md
MARQUEE_SCAN -- requirements
Module: marquee_scan

Interface
REQ-001 Parameter ROWS, default 8, number of matrix rows (2..32).
REQ-002 Parameter COLS, default 8, number of matrix columns (2..32).
REQ-003 Parameter CLK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-004 Parameter STEP_HZ, default 2, pattern step rate in Hz.
REQ-005 Parameter SCAN_HZ, default 8_000, row-scan rate in Hz.
REQ-006 Parameter DEBOUNCE_MS, default 20, button debounce time in ms.
REQ-007 clk  input  1  single system clock; all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 btn_color  input  1  raw colour button, asynchronous, pressed = low.
REQ-010 btn_mode  input  1  raw mode button, asynchronous, pressed = low.
REQ-011 led_row  output  ROWS  row drive, one-hot, active-high.
REQ-012 led_col_r / led_col_g / led_col_b  output  COLS each  column drives, active-low.
REQ-013 led_hb  output  1  heartbeat, toggles on every step tick.

Function
REQ-014 Each button SHALL pass a 2-flop synchroniser, then a debouncer accepting a new level only after DBC = DEBOUNCE_MS*CLK_FREQ/1000 consecutive cycles differing from the current debounced level.
REQ-015 A debounced high->low transition SHALL produce exactly one 1-cycle press pulse; release produces none.
REQ-016 Step counter SHALL count 0..CLK_FREQ/STEP_HZ-1 and emit step_tick on the terminal count, then wrap to 0.
REQ-017 Scan counter SHALL count 0..CLK_FREQ/SCAN_HZ-1; on terminal count led_row rotates one-hot toward MSB, row ROWS-1 wraps to row 0.
REQ-018 Colour register col[2:0] = {b,g,r}; colour press SHALL advance col by 1, 7 wraps to 0 (0 = all off).
REQ-019 Mode register SHALL hold 4 states: LEFT(0), RIGHT(1), BOUNCE(2), FILL(3); mode press advances by 1, FILL wraps to LEFT.
REQ-020 Any press (colour or mode) SHALL clear position pos to 0, direction to up, and step counter to 0; effect visible on outputs next cycle.
REQ-021 Colour and mode presses in the same cycle SHALL both be applied.
REQ-022 A press coinciding with step_tick SHALL win; that step is dropped.
REQ-023 On step_tick: LEFT pos = (pos+1) mod COLS; RIGHT pos = (pos-1) mod COLS; BOUNCE moves pos by +/-1 and reverses direction on reaching COLS-1 or 0 (sequence 0,1..COLS-1,COLS-2..0,1..); FILL pos = (pos+1) mod COLS.
REQ-024 Pattern: LEFT/RIGHT/BOUNCE light only column pos; FILL lights columns 0..pos inclusive.
REQ-025 led_col_x SHALL equal ~(pattern AND {COLS{col[x]}}) for x in r,g,b; all rows show the same pattern.
REQ-026 All outputs SHALL be registered; 1-cycle latency from internal state to pins.

Reset
REQ-027 rst SHALL, on the next rising clk edge, set: col = 1 (red), mode = LEFT, pos = 0, direction up, all counters 0, debounced levels = 1 (released), synchronisers = 1.
REQ-028 During and in the cycle after reset: led_row = 0, all led_col_x = all-ones, led_hb = 0; first row drive (row 0) appears the following cycle.
REQ-029 rst asserted mid-press or mid-debounce SHALL discard the pending press; no pulse is generated after reset releases unless the button is released and re-pressed.

Configuration
REQ-030 Macro MARQUEE_PAUSE_EN: when defined, an input btn_pause (1 bit, raw, pressed = low, synchronised and debounced per REQ-014) is added; each press toggles a paused flag (reset 0); while paused the step counter holds and no step_tick occurs, scanning continues.
REQ-031 Without MARQUEE_PAUSE_EN, port btn_pause and the pause logic are absent; stepping never stops.

Verification (CLK_FREQ=1000, STEP_HZ=100, SCAN_HZ=500, DEBOUNCE_MS=2, ROWS=COLS=8)
REQ-032 Reset then idle 40 cycles -> led_col_r cycles 0xFE,0xFD,0xFB,0xF7 every 10 cycles; led_col_g/b = 0xFF; led_row rotates every 2 cycles; led_hb toggles every 10.
REQ-033 btn_color low with 1-cycle glitch, then held low 5 cycles -> glitch ignored; exactly one press; col 1->2, led_col_g = 0xFE, led_col_r = 0xFF, pos restarts at 0.
REQ-034 Mode pressed to BOUNCE, run 150 cycles -> lit column sequence 0..7,6..0,1; no repeat of 7 or 0 at reversal.
REQ-035 Mode to FILL, col=7 -> all three col buses 0xFE,0xFC,...,0x00, then 0xFE.
REQ-036 Colour and mode press pulses in the same cycle as step_tick -> both registers advance, pos = 0, step counter 0, no step applied.
REQ-037 rst asserted for 1 cycle in mid-debounce of btn_mode held low -> no mode change; outputs at reset values per REQ-028.
